// File: rtl/lightstand_pkg.sv
// rtl/lightstand_pkg.sv - shared lightstand mode, select and state encodings
// Contents:
//   MODE_*  : front-panel mode encodings (i_mode)
//   SEL_*   : 5:1 channel mux select values, also used by the mux itself
//   state_t : sequencer state; values equal the mode that selects them
//   sel_is_chan() : 1 when a select value routes a real channel (1..4)
package lightstand_pkg;

  localparam int SEL_W = 3;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_FWD    = 2'b10;
  localparam logic [1:0] MODE_PP     = 2'b11;

  localparam logic [SEL_W-1:0] SEL_OFF = 3'd0;
  localparam logic [SEL_W-1:0] SEL_CH1 = 3'd1;
  localparam logic [SEL_W-1:0] SEL_CH2 = 3'd2;
  localparam logic [SEL_W-1:0] SEL_CH3 = 3'd3;
  localparam logic [SEL_W-1:0] SEL_CH4 = 3'd4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_OFF    = MODE_OFF,
    S_MANUAL = MODE_MANUAL,
    S_FWD    = MODE_FWD,
    S_PP     = MODE_PP
  } state_t;

  function automatic logic sel_is_chan(input logic [SEL_W-1:0] sel);
    return (sel >= SEL_CH1) && (sel <= SEL_CH4);
  endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// rtl/mux_select_sequencer_if.sv - front-panel inputs and mux select outputs of the sequencer
// Signals:
//   i_enable  : 1 = run, 0 = freeze
//   i_mode    : 2-bit mode (see MODE_*)
//   i_step    : debounced step button level
//   i_dwell   : dwell ticks per channel in auto modes
//   o_select  : mux select 0..4
//   o_ch_valid: 1 when o_select != 0
//   o_wrap    : one-cycle pulse on restart at channel 1
// Modports: master drives the inputs (front panel / bench), slave is the sequencer.
interface mux_select_sequencer_if
  import lightstand_pkg::*;
#(
  parameter int DWELL_W = 8
);
  logic               i_enable;
  logic [1:0]         i_mode;
  logic               i_step;
  logic [DWELL_W-1:0] i_dwell;
  logic [SEL_W-1:0]   o_select;
  logic               o_ch_valid;
  logic               o_wrap;

  modport master (
    output i_enable, i_mode, i_step, i_dwell,
    input  o_select, o_ch_valid, o_wrap
  );

  modport slave (
    input  i_enable, i_mode, i_step, i_dwell,
    output o_select, o_ch_valid, o_wrap
  );
endinterface

// File: rtl/mux_select_sequencer_tick_prescaler.sv
// rtl/mux_select_sequencer_tick_prescaler.sv - dwell tick prescaler, one tick per TICK_DIV running cycles
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_run   : count this cycle
//   i_clear : return count to 0 (wins over i_run)
//   o_tick  : high in the running cycle where count == TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // With TICK_DIV=1 LAST is 0, so count never leaves 0 and every running cycle ticks.
  assign o_tick = i_run && !i_clear && (count == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - sequences the 3-bit select of the lightstand 5:1 channel mux
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of mux_select_sequencer_if (enable/mode/step/dwell in,
//             select/ch_valid/wrap out, all outputs registered)
module mux_select_sequencer
  import lightstand_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DWELL_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  mux_select_sequencer_if.slave   bus
);
  state_t             state, nxt_state;
  logic [SEL_W-1:0]   sel_q, nxt_sel, adv_sel;
  logic               ch_valid_q, wrap_q, nxt_wrap, adv_wrap;
  logic               dir_q, nxt_dir, adv_dir;
  logic [DWELL_W-1:0] dwell_cnt, nxt_dwell, eff;
  logic               step_q, step_edge, tick, mode_change, auto_mode, dwell_done;

  assign mode_change = bus.i_enable && (bus.i_mode != state);
  assign auto_mode   = (state == S_FWD) || (state == S_PP);
  assign step_edge   = bus.i_step & ~step_q;
  assign eff         = (bus.i_dwell == '0) ? DWELL_W'(1) : bus.i_dwell;
  assign dwell_done  = dwell_cnt >= (eff - DWELL_W'(1));

  // Prescaler freezes with i_enable=0 and sits at 0 outside the auto modes
  // and on every mode entry, so a fresh auto run gets a full first dwell.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_run   (bus.i_enable && auto_mode && !mode_change),
    .i_clear (bus.i_enable && (mode_change || !auto_mode)),
    .o_tick  (tick)
  );

  // Next channel for one advance step in the current state.
  always_comb begin
    adv_sel  = SEL_CH1;
    adv_dir  = dir_q;
    adv_wrap = 1'b0;
    if (state == S_PP) begin
      if (dir_q == DIR_UP) begin
        if (sel_q >= SEL_CH3) begin
          adv_sel = SEL_CH4;
          adv_dir = DIR_DOWN;
        end else begin
          adv_sel = sel_q + SEL_W'(1);
        end
      end else begin
        if (sel_q <= SEL_CH2) begin
          adv_sel  = SEL_CH1;
          adv_dir  = DIR_UP;
          adv_wrap = 1'b1;
        end else begin
          adv_sel = sel_q - SEL_W'(1);
        end
      end
    end else if (sel_q == SEL_CH4) begin
      adv_wrap = 1'b1;
    end else begin
      adv_sel = sel_q + SEL_W'(1);
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_sel   = sel_q;
    nxt_dir   = dir_q;
    nxt_dwell = dwell_cnt;
    nxt_wrap  = 1'b0;
    if (bus.i_enable) begin
      if (mode_change) begin
        nxt_state = state_t'(bus.i_mode);
        nxt_sel   = (bus.i_mode == MODE_OFF) ? SEL_OFF : SEL_CH1;
        nxt_dir   = DIR_UP;
        nxt_dwell = '0;
      end else begin
        case (state)
          S_OFF: begin
            nxt_sel   = SEL_OFF;
            nxt_dir   = DIR_UP;
            nxt_dwell = '0;
          end
          S_MANUAL: begin
            if (!sel_is_chan(sel_q)) begin
              nxt_sel = SEL_CH1;
            end else if (step_edge) begin
              nxt_sel  = adv_sel;
              nxt_wrap = adv_wrap;
            end
          end
          default: begin
            if (!sel_is_chan(sel_q)) begin
              nxt_sel = SEL_CH1;
            end else if (tick) begin
              if (dwell_done) begin
                nxt_sel   = adv_sel;
                nxt_dir   = adv_dir;
                nxt_wrap  = adv_wrap;
                nxt_dwell = '0;
              end else begin
                nxt_dwell = dwell_cnt + DWELL_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_OFF;
      sel_q      <= SEL_OFF;
      ch_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
      dir_q      <= DIR_UP;
      dwell_cnt  <= '0;
      step_q     <= 1'b0;
    end else begin
      state      <= nxt_state;
      sel_q      <= nxt_sel;
      ch_valid_q <= (nxt_sel != SEL_OFF);
      wrap_q     <= nxt_wrap;
      dir_q      <= nxt_dir;
      dwell_cnt  <= nxt_dwell;
      // Sampled even while disabled so a held button cannot fake an edge on re-enable.
      step_q     <= bus.i_step;
    end
  end

  assign bus.o_select   = sel_q;
  assign bus.o_ch_valid = ch_valid_q;
  assign bus.o_wrap     = wrap_q;
endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - directed self-checking bench for mux_select_sequencer
module tb_mux_select_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_select_sequencer_if #(.DWELL_W(8)) bus ();

  mux_select_sequencer #(.TICK_DIV(4), .DWELL_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_mode = 2'b10;
    bus.i_step = 1'b0;
    bus.i_dwell = 8'd2;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_select !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.o_select); end
    checks++; if (bus.o_ch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_ch_valid); end
    checks++; if (bus.o_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", bus.o_wrap); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1) begin errors++; $display("FAIL release_sel got=%0d exp=1", bus.o_select); end
    checks++; if (bus.o_ch_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%b exp=1", bus.o_ch_valid); end
  endtask

  // dwell=2, TICK_DIV=4: 8 cycles per channel
  task automatic test_fwd();
    int seq[4] = '{2, 3, 4, 1};
    int prev = 1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c < 8) begin
          checks++; if (bus.o_select !== 3'(prev) || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL fwd_hold step=%0d cyc=%0d got=%0d/%b exp=%0d/0", k, c, bus.o_select, bus.o_wrap, prev); end
        end else begin
          checks++; if (bus.o_select !== 3'(seq[k])) begin errors++; $display("FAIL fwd_adv step=%0d got=%0d exp=%0d", k, bus.o_select, seq[k]); end
          checks++; if (bus.o_wrap !== (prev == 4 && seq[k] == 1)) begin errors++; $display("FAIL fwd_wrap step=%0d got=%b exp=%b", k, bus.o_wrap, (prev == 4 && seq[k] == 1)); end
        end
      end
      prev = seq[k];
    end
  endtask

  // dwell=0 behaves as 1: 4 cycles per channel
  task automatic test_pp();
    int seq[7] = '{2, 3, 4, 3, 2, 1, 2};
    int prev = 1;
    bus.i_mode = 2'b11;
    bus.i_dwell = 8'd0;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1 || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL pp_entry got=%0d/%b exp=1/0", bus.o_select, bus.o_wrap); end
    for (int k = 0; k < 7; k++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) begin
          checks++; if (bus.o_select !== 3'(prev) || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL pp_hold step=%0d cyc=%0d got=%0d/%b exp=%0d/0", k, c, bus.o_select, bus.o_wrap, prev); end
        end else begin
          checks++; if (bus.o_select !== 3'(seq[k])) begin errors++; $display("FAIL pp_adv step=%0d got=%0d exp=%0d", k, bus.o_select, seq[k]); end
          checks++; if (bus.o_wrap !== (prev == 2 && seq[k] == 1)) begin errors++; $display("FAIL pp_wrap step=%0d got=%b exp=%b", k, bus.o_wrap, (prev == 2 && seq[k] == 1)); end
        end
      end
      prev = seq[k];
    end
  endtask

  task automatic test_manual();
    int seq[5] = '{3, 4, 1, 2, 3};
    bus.i_mode = 2'b01;
    bus.i_step = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1) begin errors++; $display("FAIL man_entry got=%0d exp=1", bus.o_select); end
    bus.i_step = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.o_select !== 3'd2) begin errors++; $display("FAIL man_hold cyc=%0d got=%0d exp=2", c, bus.o_select); end
    end
    bus.i_step = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.i_step = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_select !== 3'(seq[k])) begin errors++; $display("FAIL man_step k=%0d got=%0d exp=%0d", k, bus.o_select, seq[k]); end
      checks++; if (bus.o_wrap !== (seq[k] == 1)) begin errors++; $display("FAIL man_wrap k=%0d got=%b exp=%b", k, bus.o_wrap, (seq[k] == 1)); end
      bus.i_step = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_select !== 3'(seq[k]) || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL man_idle k=%0d got=%0d/%b exp=%0d/0", k, bus.o_select, bus.o_wrap, seq[k]); end
    end
  endtask

  task automatic test_enable_freeze();
    bus.i_mode = 2'b10;
    bus.i_dwell = 8'd2;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1) begin errors++; $display("FAIL frz_entry got=%0d exp=1", bus.o_select); end
    repeat (16) @(negedge clk);
    checks++; if (bus.o_select !== 3'd3) begin errors++; $display("FAIL frz_reach3 got=%0d exp=3", bus.o_select); end
    repeat (3) @(negedge clk);
    bus.i_enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (bus.o_select !== 3'd3 || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL frz_hold cyc=%0d got=%0d/%b exp=3/0", c, bus.o_select, bus.o_wrap); end
    end
    bus.i_enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.o_select !== 3'd3) begin errors++; $display("FAIL frz_rest cyc=%0d got=%0d exp=3", c, bus.o_select); end
    end
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd4) begin errors++; $display("FAIL frz_resume got=%0d exp=4", bus.o_select); end
  endtask

  task automatic test_mode_switch_reset();
    bus.i_mode = 2'b00;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd0 || bus.o_ch_valid !== 1'b0) begin errors++; $display("FAIL sw_off got=%0d/%b exp=0/0", bus.o_select, bus.o_ch_valid); end
    bus.i_mode = 2'b01;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1 || bus.o_ch_valid !== 1'b1) begin errors++; $display("FAIL sw_manual got=%0d/%b exp=1/1", bus.o_select, bus.o_ch_valid); end
    repeat (3) begin
      bus.i_step = 1'b1;
      @(negedge clk);
      bus.i_step = 1'b0;
      @(negedge clk);
    end
    checks++; if (bus.o_select !== 3'd4) begin errors++; $display("FAIL sw_at4 got=%0d exp=4", bus.o_select); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd0 || bus.o_ch_valid !== 1'b0 || bus.o_wrap !== 1'b0) begin errors++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", bus.o_select, bus.o_ch_valid, bus.o_wrap); end
    bus.i_enable = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.o_select !== 3'd0) begin errors++; $display("FAIL dis_mode cyc=%0d got=%0d exp=0", c, bus.o_select); end
    end
    bus.i_enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_select !== 3'd1) begin errors++; $display("FAIL reen_mode got=%0d exp=1", bus.o_select); end
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_pp();
    test_manual();
    test_enable_freeze();
    test_mode_switch_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
